// File: rtl/mm_keyscan.sv
// Keyboard matrix scanner: walks 8 active-low columns, debounces whole-frame
// results and hands one key code per press to a 6532 via a STB/ACK handshake.
module mm_keyscan #(
    parameter int SCAN_DIV = 16,
    parameter int DEBOUNCE = 4
) (
    input  logic       CLK,
    input  logic       RES,
    output logic [7:0] COL_OUT,
    input  logic [7:0] ROW_IN,
    output logic [7:0] DATA_OUT,
    output logic       STB,
    input  logic       ACK
);
    localparam int              DW         = $clog2(SCAN_DIV);
    localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [3:0]      DEB_MAX    = 4'(DEBOUNCE);

    typedef enum logic [1:0] {IDLE, PEND, HELD} state_t;

    state_t        state, state_next;
    logic [DW-1:0] dwell;
    logic [2:0]    col;
    logic          acc_found, acc_multi;
    logic [5:0]    acc_key;
    logic [3:0]    stable, stable_next;
    logic          prev_pressed;
    logic [7:0]    prev_code;
    logic          ack_r, ack_d;
    logic [7:0]    data_next;
    logic          stb_next;

    logic          sample, frame_end;
    logic [7:0]    row_act;
    logic          row_any, row_multi;
    logic [2:0]    row_low;
    logic          fr_pressed, fr_multi;
    logic [5:0]    fr_key;
    logic [7:0]    fr_code;
    logic          match, deb_press, deb_release, ack_edge;

    assign COL_OUT   = ~(8'h01 << col);
    assign sample    = (dwell == DWELL_LAST);
    assign frame_end = sample && (col == 3'd7);
    assign ack_edge  = ack_r & ~ack_d;

    // Frame result so far, including the column being sampled this cycle.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no latch is inferred.
        row_low = 3'd0;
        row_act = ~ROW_IN;
        for (int r = 7; r >= 0; r--) begin
            if (row_act[r]) row_low = 3'(r);
        end
        row_any     = |row_act;
        row_multi   = |(row_act & (row_act - 8'd1));
        fr_pressed  = acc_found | row_any;
        fr_multi    = acc_multi | row_multi | (acc_found & row_any);
        fr_key      = acc_found ? acc_key : {col, row_low};
        fr_code     = fr_pressed ? {1'b0, fr_multi, fr_key} : 8'h00;
        match       = (fr_pressed == prev_pressed) && (fr_code == prev_code);
        stable_next = !match ? 4'd1 : ((stable == DEB_MAX) ? stable : stable + 4'd1);
        deb_press   = frame_end && (stable_next == DEB_MAX) && fr_pressed;
        deb_release = frame_end && (stable_next == DEB_MAX) && !fr_pressed;
    end

    always_comb begin
        state_next = state;
        data_next  = DATA_OUT;
        stb_next   = STB;
        case (state)
            IDLE: begin
                if (deb_press) begin
                    data_next  = fr_code;
                    stb_next   = 1'b1;
                    state_next = PEND;
                end
            end
            PEND: begin
                if (ack_edge) begin
                    stb_next   = 1'b0;
                    state_next = HELD;
                end
            end
            HELD: begin
                // A held key is never re-reported; only a different code is.
                if (deb_release) begin
                    state_next = IDLE;
                end else if (deb_press && (fr_code != DATA_OUT)) begin
                    data_next  = fr_code;
                    stb_next   = 1'b1;
                    state_next = PEND;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments make all register updates see pre-edge values.
        if (RES) begin
            state        <= IDLE;
            dwell        <= '0;
            col          <= 3'd0;
            acc_found    <= 1'b0;
            acc_multi    <= 1'b0;
            acc_key      <= 6'd0;
            stable       <= 4'd0;
            prev_pressed <= 1'b0;
            prev_code    <= 8'h00;
            ack_r        <= 1'b0;
            ack_d        <= 1'b0;
            DATA_OUT     <= 8'h00;
            STB          <= 1'b0;
        end else begin
            ack_r <= ACK;
            ack_d <= ack_r;
            if (sample) begin
                dwell <= '0;
                col   <= col + 3'd1;
                if (frame_end) begin
                    acc_found    <= 1'b0;
                    acc_multi    <= 1'b0;
                    acc_key      <= 6'd0;
                    stable       <= stable_next;
                    prev_pressed <= fr_pressed;
                    prev_code    <= fr_code;
                end else begin
                    acc_found <= fr_pressed;
                    acc_multi <= fr_multi;
                    acc_key   <= fr_key;
                end
            end else begin
                dwell <= dwell + DW'(1);
            end
            state    <= state_next;
            DATA_OUT <= data_next;
            STB      <= stb_next;
        end
    end
endmodule

// File: tb/tb_mm_keyscan.sv
// Self-checking bench for mm_keyscan: a key-matrix model drives ROW_IN and a
// frame-level reference model predicts STB, DATA_OUT and COL_OUT every cycle.
`timescale 1ns/1ps
module tb_mm_keyscan;
    localparam int SD = 4;
    localparam int DB = 3;
    localparam int FRAME = 8 * SD;

    typedef enum int {M_IDLE, M_PEND, M_HELD} mstate_t;

    logic             CLK = 1'b0;
    logic             RES = 1'b1;
    logic             ACK = 1'b0;
    logic [7:0]       COL_OUT, ROW_IN, DATA_OUT;
    logic             STB;
    logic [7:0][7:0]  keys = '0;   // keys[col][row] = 1 means pressed

    int checks = 0;
    int errors = 0;

    mm_keyscan #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .CLK(CLK), .RES(RES), .COL_OUT(COL_OUT), .ROW_IN(ROW_IN),
        .DATA_OUT(DATA_OUT), .STB(STB), .ACK(ACK)
    );

    always #5 CLK = ~CLK;

    // Passive matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        ROW_IN = 8'hFF;
        for (int c = 0; c < 8; c++) begin
            if (!COL_OUT[c]) ROW_IN = ROW_IN & ~keys[c];
        end
    end

    // Reference model: keys seen at each column's sample slot, judged per frame.
    int              m_cyc;
    int              m_stable;
    logic            m_prev_p;
    logic [7:0]      m_prev_code;
    mstate_t         m_state;
    logic [7:0][7:0] m_rows;
    logic            m_ack1, m_ack2;
    logic            exp_stb;
    logic [7:0]      exp_data, exp_col;

    always @(posedge CLK) begin : ref_model
        int              col, nkeys, fc, fr, st;
        bit              fe, p, multi, ack_seen;
        logic [7:0]      code, ndata;
        logic [7:0][7:0] rows;
        logic            nstb;
        mstate_t         nstate;
        if (RES) begin
            m_cyc       <= 0;
            m_stable    <= 0;
            m_prev_p    <= 1'b0;
            m_prev_code <= 8'h00;
            m_state     <= M_IDLE;
            m_rows      <= '0;
            m_ack1      <= 1'b0;
            m_ack2      <= 1'b0;
            exp_stb     <= 1'b0;
            exp_data    <= 8'h00;
            exp_col     <= 8'hFE;
        end else begin
            col      = (m_cyc / SD) % 8;
            rows     = m_rows;
            fe       = 1'b0;
            p        = 1'b0;
            code     = 8'h00;
            st       = m_stable;
            ack_seen = m_ack1 && !m_ack2;
            if (m_cyc % SD == SD - 1) begin
                rows[col] = keys[col];
                if (col == 7) begin
                    fe = 1'b1;
                    nkeys = 0;
                    fc = -1;
                    fr = 0;
                    for (int c = 0; c < 8; c++)
                        for (int r = 0; r < 8; r++)
                            if (rows[c][r]) begin
                                nkeys++;
                                if (fc < 0) begin fc = c; fr = r; end
                            end
                    p     = (nkeys > 0);
                    multi = (nkeys > 1);
                    code  = p ? {1'b0, multi, 3'(fc), 3'(fr)} : 8'h00;
                    st    = (p == m_prev_p && code == m_prev_code) ?
                            ((m_stable < DB) ? m_stable + 1 : DB) : 1;
                    m_stable    <= st;
                    m_prev_p    <= p;
                    m_prev_code <= code;
                end
            end
            m_rows <= rows;
            nstate = m_state;
            ndata  = exp_data;
            nstb   = exp_stb;
            case (m_state)
                M_IDLE: if (fe && st == DB && p) begin
                    ndata = code; nstb = 1'b1; nstate = M_PEND;
                end
                M_PEND: if (ack_seen) begin
                    nstb = 1'b0; nstate = M_HELD;
                end
                M_HELD: if (fe && st == DB && !p) begin
                    nstate = M_IDLE;
                end else if (fe && st == DB && p && code != exp_data) begin
                    ndata = code; nstb = 1'b1; nstate = M_PEND;
                end
                default: nstate = M_IDLE;
            endcase
            m_state  <= nstate;
            exp_data <= ndata;
            exp_stb  <= nstb;
            m_ack2   <= m_ack1;
            m_ack1   <= ACK;
            m_cyc    <= m_cyc + 1;
            exp_col  <= ~(8'h01 << (((m_cyc + 1) / SD) % 8));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input int n);
        RES = 1'b1;
        repeat (n) tick();
        RES = 1'b0;
    endtask

    task automatic test_reset();
        keys = '0;
        ACK  = 1'b0;
        do_reset(2);
        checks++;
        if ({COL_OUT, STB, DATA_OUT} !== {8'hFE, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_values: col=%h stb=%b data=%h, expected FE/0/00", COL_OUT, STB, DATA_OUT);
        end
        for (int i = 1; i <= 40; i++) begin
            tick();
            checks++;
            if ({STB, DATA_OUT, COL_OUT} !== {exp_stb, exp_data, exp_col}) begin
                errors++;
                $display("FAIL reset_trace cyc %0d: stb/data/col=%b/%h/%h expected %b/%h/%h", i, STB, DATA_OUT, COL_OUT, exp_stb, exp_data, exp_col);
            end
            if (i == 4 || i == 32) begin
                checks++;
                if (COL_OUT !== ((i == 4) ? 8'hFD : 8'hFE)) begin
                    errors++;
                    $display("FAIL reset_col_step cyc %0d: col=%h expected %h", i, COL_OUT, (i == 4) ? 8'hFD : 8'hFE);
                end
            end
        end
    endtask

    task automatic test_single_key();
        keys    = '0;
        keys[2] = 8'h20;
        ACK     = 1'b0;
        do_reset(2);
        for (int i = 1; i <= 3 * FRAME; i++) begin
            tick();
            checks++;
            if ({STB, DATA_OUT, COL_OUT} !== {exp_stb, exp_data, exp_col}) begin
                errors++;
                $display("FAIL single_trace cyc %0d: stb/data/col=%b/%h/%h expected %b/%h/%h", i, STB, DATA_OUT, COL_OUT, exp_stb, exp_data, exp_col);
            end
            if (i >= 3 * FRAME - 1) begin
                checks++;
                if ({STB, DATA_OUT} !== ((i == 3 * FRAME) ? {1'b1, 8'h15} : {1'b0, 8'h00})) begin
                    errors++;
                    $display("FAIL single_strobe cyc %0d: stb=%b data=%h", i, STB, DATA_OUT);
                end
            end
        end
        ACK = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            tick();
            checks++;
            if (STB !== (i == 1)) begin
                errors++;
                $display("FAIL single_ack cyc %0d after ACK: stb=%b expected %b", i, STB, (i == 1));
            end
        end
        for (int i = 1; i <= 10 * FRAME; i++) begin
            tick();
            if (i == 5) ACK = 1'b0;
            checks++;
            if ({STB, DATA_OUT} !== {1'b0, 8'h15} || {STB, DATA_OUT, COL_OUT} !== {exp_stb, exp_data, exp_col}) begin
                errors++;
                $display("FAIL single_held cyc %0d: stb/data/col=%b/%h/%h expected 0/15/%h", i, STB, DATA_OUT, COL_OUT, exp_col);
            end
        end
    endtask

    task automatic test_repress();
        bit got;
        keys = '0;
        for (int i = 1; i <= 4 * FRAME; i++) begin
            tick();
            checks++;
            if (STB !== 1'b0 || {STB, DATA_OUT, COL_OUT} !== {exp_stb, exp_data, exp_col}) begin
                errors++;
                $display("FAIL repress_release cyc %0d: stb/data/col=%b/%h/%h expected %b/%h/%h", i, STB, DATA_OUT, COL_OUT, exp_stb, exp_data, exp_col);
            end
        end
        keys[2] = 8'h20;
        got = 1'b0;
        for (int i = 1; i <= 5 * FRAME && !got; i++) begin
            tick();
            checks++;
            if ({STB, DATA_OUT, COL_OUT} !== {exp_stb, exp_data, exp_col}) begin
                errors++;
                $display("FAIL repress_trace cyc %0d: stb/data/col=%b/%h/%h expected %b/%h/%h", i, STB, DATA_OUT, COL_OUT, exp_stb, exp_data, exp_col);
            end
            got = STB;
        end
        checks++;
        if (!got || DATA_OUT !== 8'h15) begin
            errors++;
            $display("FAIL repress_second_stb: stb=%b data=%h expected 1/15", got, DATA_OUT);
        end
        keys    = '0;
        keys[7] = 8'h80;
        for (int i = 1; i <= 4 * FRAME; i++) begin
            tick();
            checks++;
            if ({STB, DATA_OUT} !== {1'b1, 8'h15} || {STB, DATA_OUT, COL_OUT} !== {exp_stb, exp_data, exp_col}) begin
                errors++;
                $display("FAIL pend_frozen cyc %0d: stb/data=%b/%h expected 1/15", i, STB, DATA_OUT);
            end
        end
        ACK = 1'b1;
        got = 1'b0;
        for (int i = 1; i <= 8 && !got; i++) begin
            tick();
            got = !STB;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL pend_ack_clear: stb=%b expected 0 within 8 cycles", STB);
        end
        got = 1'b0;
        for (int i = 1; i <= 3 * FRAME && !got; i++) begin
            tick();
            checks++;
            if ({STB, DATA_OUT, COL_OUT} !== {exp_stb, exp_data, exp_col}) begin
                errors++;
                $display("FAIL held_new_code cyc %0d: stb/data/col=%b/%h/%h expected %b/%h/%h", i, STB, DATA_OUT, COL_OUT, exp_stb, exp_data, exp_col);
            end
            got = STB;
        end
        checks++;
        if (!got || DATA_OUT !== 8'h3F) begin
            errors++;
            $display("FAIL held_report_3f: stb=%b data=%h expected 1/3F", got, DATA_OUT);
        end
        ACK = 1'b0;
    endtask

    task automatic test_bounce();
        keys = '0;
        ACK  = 1'b0;
        do_reset(2);
        for (int f = 0; f < 12; f++) begin
            keys[2] = (f % 2 == 0) ? 8'h20 : 8'h00;
            for (int i = 0; i < FRAME; i++) begin
                tick();
                checks++;
                if ({STB, DATA_OUT} !== {1'b0, 8'h00} || {STB, DATA_OUT, COL_OUT} !== {exp_stb, exp_data, exp_col}) begin
                    errors++;
                    $display("FAIL bounce frame %0d cyc %0d: stb/data=%b/%h expected 0/00", f, i, STB, DATA_OUT);
                end
            end
        end
    endtask

    task automatic test_two_keys();
        keys    = '0;
        keys[1] = 8'h01;
        keys[3] = 8'h04;
        ACK     = 1'b0;
        do_reset(2);
        repeat (3 * FRAME) tick();
        checks++;
        if ({STB, DATA_OUT} !== {1'b1, 8'h48}) begin
            errors++;
            $display("FAIL two_keys: stb=%b data=%h expected 1/48", STB, DATA_OUT);
        end
    endtask

    task automatic test_reset_in_pend();
        keys    = '0;
        keys[2] = 8'h20;
        ACK     = 1'b0;
        do_reset(2);
        repeat (3 * FRAME + 5) tick();
        checks++;
        if (STB !== 1'b1) begin
            errors++;
            $display("FAIL rst_pend_setup: stb=%b expected 1", STB);
        end
        do_reset(1);
        checks++;
        if ({STB, DATA_OUT, COL_OUT} !== {1'b0, 8'h00, 8'hFE}) begin
            errors++;
            $display("FAIL rst_pend_clear: stb/data/col=%b/%h/%h expected 0/00/FE", STB, DATA_OUT, COL_OUT);
        end
        for (int i = 1; i <= 3 * FRAME; i++) begin
            tick();
            if (i >= 3 * FRAME - 1) begin
                checks++;
                if ({STB, DATA_OUT} !== ((i == 3 * FRAME) ? {1'b1, 8'h15} : {1'b0, 8'h00})) begin
                    errors++;
                    $display("FAIL rst_pend_restrobe cyc %0d: stb=%b data=%h", i, STB, DATA_OUT);
                end
            end
        end
    endtask

    task automatic test_random();
        int c, r, n;
        keys = '0;
        ACK  = 1'b0;
        do_reset(2);
        for (int i = 1; i <= 1600; i++) begin
            tick();
            checks++;
            if ({STB, DATA_OUT, COL_OUT} !== {exp_stb, exp_data, exp_col}) begin
                errors++;
                $display("FAIL random cyc %0d: stb/data/col=%b/%h/%h expected %b/%h/%h", i, STB, DATA_OUT, COL_OUT, exp_stb, exp_data, exp_col);
            end
            if ($urandom_range(0, 59) == 0) begin
                keys = '0;
                n = $urandom_range(0, 2);
                for (int k = 0; k < n; k++) begin
                    c = $urandom_range(0, 7);
                    r = $urandom_range(0, 7);
                    keys[c][r] = 1'b1;
                end
            end
            if ($urandom_range(0, 19) == 0) ACK = ~ACK;
        end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_repress();
        test_bounce();
        test_two_keys();
        test_reset_in_pend();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mm_keyscan.md
MM_KEYSCAN -- requirements
Module: mm_keyscan

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 16: clock cycles each column is driven; legal values 2..256.
REQ-002 The block SHALL have parameter DEBOUNCE, default 4: consecutive identical frame results needed to accept a press or release; legal values 1..15.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RES, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port COL_OUT, output, 8 bits: keyboard column drive, active-low, exactly one bit low.
REQ-006 The block SHALL have port ROW_IN, input, 8 bits: keyboard row sense, active-low, pulled up externally.
REQ-007 The block SHALL have port DATA_OUT, output, 8 bits: key code, feeds the 6532 port B input.
REQ-008 The block SHALL have port STB, output, 1 bit: key-ready strobe, feeds 6532 PA7 so the positive-edge PA7 interrupt fires.
REQ-009 The block SHALL have port ACK, input, 1 bit: acknowledge, driven from a 6532 port A output bit.

Function
REQ-010 Scan timing SHALL be: dwell counter 0..SCAN_DIV-1; ROW_IN sampled when dwell = SCAN_DIV-1; column index (0..7, wraps 7->0) advances on the next cycle; COL_OUT = ~(1 << column).
REQ-011 A frame SHALL be 8*SCAN_DIV cycles; frame-end is the sample cycle of column 7.
REQ-012 Frame result SHALL be: pressed = any sampled row bit 0 in the frame; code = lowest column, then lowest row, among pressed keys; multi = more than one key pressed in the frame.
REQ-013 Code format SHALL be: bit 7 = 0; bit 6 = multi; bits 5:3 = column; bits 2:0 = row.
REQ-014 Debounce SHALL work as follows at each frame-end: if {pressed, code} equals the previous frame result, stable count increments, saturating at DEBOUNCE; otherwise it loads 1.
REQ-015 A debounced press is stable count = DEBOUNCE with pressed = 1; a debounced release is stable count = DEBOUNCE with pressed = 0.
REQ-016 The FSM SHALL have states IDLE, PEND and HELD.
REQ-017 In IDLE, a debounced press SHALL load DATA_OUT with the code, set STB = 1 and enter PEND; this occurs on the cycle after the frame-end sample.
REQ-018 In PEND, STB SHALL stay 1 and DATA_OUT SHALL be frozen; new presses and releases are ignored; no queueing.
REQ-019 ACK rising edge SHALL be detected on a registered ACK, 0->1. In PEND it clears STB on the next cycle and enters HELD. In IDLE or HELD it is ignored.
REQ-020 ACK held high across entry to PEND SHALL NOT count as an edge.
REQ-021 In HELD, a debounced release SHALL enter IDLE, with DATA_OUT retained.
REQ-022 In HELD, a debounced press with a code different from DATA_OUT SHALL report that code (load, STB = 1, enter PEND). The same code SHALL NOT be re-reported.
REQ-023 Scanning and debounce SHALL run continuously in all states.

Reset
REQ-024 While RES = 1, at each rising CLK the block SHALL set: COL_OUT = 8'hFE, DATA_OUT = 8'h00, STB = 0, state IDLE, dwell = 0, column = 0, stable count = 0, previous result = not-pressed/code 0, registered ACK = 0.
REQ-025 Reset SHALL override all other activity, including mid-PEND and mid-frame. The first post-reset frame starts at column 0, dwell 0.

Verification (SCAN_DIV=4, DEBOUNCE=3, frame = 32 cycles)
REQ-026 Reset: RES=1 for 2 cycles, then 0 -> COL_OUT = FE, STB = 0, DATA_OUT = 00; COL_OUT = FD 4 cycles after RES falls; back to FE after 32 cycles.
REQ-027 Single key: column 2 / row 5 held from reset release -> STB = 1 one cycle after the 3rd frame-end, DATA_OUT = 8'h15. ACK 0->1 -> STB = 0 one cycle after the registered edge. Key kept held for 10 frames -> no second STB.
REQ-028 Bounce: key column 2 / row 5 present on alternate frames only, for 12 frames -> STB stays 0, DATA_OUT stays 00.
REQ-029 Two keys, column 1 / row 0 and column 3 / row 2, held -> DATA_OUT = 8'h48, STB = 1.
REQ-030 Re-press: after the REQ-027 sequence, release for 3 frames (state IDLE) then press again -> second STB with DATA_OUT = 8'h15. Press column 7 / row 7 while in PEND then ACK -> HELD, then report 8'h3F after debounce.
REQ-031 Reset in PEND: RES=1 for 1 cycle while STB=1 and the key stays held -> STB = 0, DATA_OUT = 00 immediately; STB = 1 again with 8'h15 one cycle after the 3rd frame-end after reset.
